// File: rtl/round_robin_mux_4.sv
`default_nettype none
// ============================================================================
// Module  : round_robin_mux_4
// Brief   : 4-channel round-robin arbiter feeding a single registered output.
// Revision: 1.0 - initial release
// ============================================================================
module round_robin_mux_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  localparam logic [1:0] c_ptr_reset = 2'd0;

  logic [1:0]       r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_sel;

  logic             w_load;
  logic             w_any;
  logic [1:0]       w_idx;
  logic [3:0]       w_grant;
  logic [WIDTH-1:0] w_data;

  // Scan lowest priority first so the highest-priority requester wins last.
  always_comb begin
    logic [1:0] cand;
    w_any = 1'b0;
    w_idx = r_ptr;
    cand  = r_ptr;
    for (int off = 3; off >= 0; off--) begin
      cand = r_ptr + 2'(off);
      if (in_valid[cand]) begin
        w_any = 1'b1;
        w_idx = cand;
      end
    end
  end

  always_comb begin
    w_data = in_data0;
    case (w_idx)
      2'd0:    w_data = in_data0;
      2'd1:    w_data = in_data1;
      2'd2:    w_data = in_data2;
      default: w_data = in_data3;
    endcase
  end

  assign w_grant  = w_any ? (4'b0001 << w_idx) : 4'b0000;
  assign w_load   = !r_out_valid || out_ready;
  assign in_ready = w_load ? w_grant : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= c_ptr_reset;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sel   <= w_idx;
        r_ptr       <= w_idx + 2'd1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_mux_4.sv
`default_nettype none
// Scoreboard bench for round_robin_mux_4: reference arbiter model predicts
// grants and pushes expected beats; a monitor pops them on output transfers.
module tb_round_robin_mux_4;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  round_robin_mux_4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int sel; int data; } beat_t;
  beat_t q[$];

  int checks = 0;
  int failures = 0;
  int m_ptr = 0;
  bit m_ov = 0;
  int waits[4];
  logic [3:0] last_ready = 4'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan_data(input int c);
    case (c)
      0: return int'(in_data0);
      1: return int'(in_data1);
      2: return int'(in_data2);
      default: return int'(in_data3);
    endcase
  endfunction

  // One clock cycle: drive at negedge+2, predict and check at negedge+3.
  task automatic step(input logic [3:0] v, input logic [4*W-1:0] d, input logic r);
    int k;
    bit load;
    int exp_ready;
    beat_t b;
    @(negedge clk);
    #2;
    in_valid  = v;
    in_data0  = d[W-1:0];
    in_data1  = d[2*W-1:W];
    in_data2  = d[3*W-1:2*W];
    in_data3  = d[4*W-1:3*W];
    out_ready = r;
    #1;
    load = !m_ov || r;
    k = -1;
    for (int off = 0; off < 4; off++)
      if (k < 0 && v[(m_ptr + off) % 4]) k = (m_ptr + off) % 4;
    exp_ready = (load && k >= 0) ? (1 << k) : 0;
    chk("in_ready", int'(in_ready), exp_ready);
    chk("out_valid", int'(out_valid), int'(m_ov));
    if (m_ov && q.size() > 0) begin
      chk("held_data", int'(out_data), q[0].data);
      chk("held_sel", int'(out_sel), q[0].sel);
    end
    if (in_ready != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && !in_ready[i]) begin
          waits[i]++;
          chk($sformatf("starve_ch%0d", i), int'(waits[i] <= 3), 1);
        end else begin
          waits[i] = 0;
        end
      end
    end
    for (int i = 0; i < 4; i++) if (!v[i]) waits[i] = 0;
    if (load) begin
      if (k >= 0) begin
        b.sel = k;
        b.data = chan_data(k);
        q.push_back(b);
        m_ov = 1;
        m_ptr = (k + 1) % 4;
      end else begin
        m_ov = 0;
      end
    end
    last_ready = in_ready;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    #1;
    in_valid = 4'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    q.delete();
    m_ptr = 0;
    m_ov = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    last_ready = 4'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: just before each rising edge, an output transfer consumes a beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got sel=%0d data=%0d expected none", out_sel, out_data);
        end else begin
          b = q.pop_front();
          chk("mon_sel", int'(out_sel), b.sel);
          chk("mon_data", int'(out_data), b.data);
        end
      end
    end
  end

  logic [3:0]       rv;
  logic [4*W-1:0]   rd;

  initial begin
    rst_n = 1'b0;
    in_valid = 4'b0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    #1;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_out_data", int'(out_data), 0);
    chk("init_out_sel", int'(out_sel), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // All channels requesting: grants 0,1,2,3,0
    for (int c = 0; c < 5; c++) step(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Lone channel 2 with a stalled output
    pulse_reset();
    step(4'b0100, {4'h0, 4'hA, 4'h0, 4'h0}, 1'b0);
    step(4'b0100, {4'h0, 4'hB, 4'h0, 4'h0}, 1'b0);
    step(4'b0100, {4'h0, 4'hB, 4'h0, 4'h0}, 1'b0);
    step(4'b0100, {4'h0, 4'hB, 4'h0, 4'h0}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Pointer wrap: ptr=3 after granting 2, then 3, then 0
    step(4'b0100, {4'h0, 4'h5, 4'h0, 4'h0}, 1'b1);
    step(4'b1001, {4'h7, 4'h0, 4'h0, 4'h6}, 1'b1);
    step(4'b1001, {4'h9, 4'h0, 4'h0, 4'h8}, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Replace on the edge where a stalled beat leaves
    step(4'b0010, {4'h0, 4'h0, 4'hC, 4'h0}, 1'b0);
    step(4'b0000, '0, 1'b0);
    step(4'b0010, {4'h0, 4'h0, 4'hD, 4'h0}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Reset mid-stream, then order restarts at channel 0
    step(4'b1111, {4'h4, 4'h3, 4'h2, 4'h1}, 1'b1);
    step(4'b1111, {4'h4, 4'h3, 4'h2, 4'h1}, 1'b0);
    pulse_reset();
    for (int c = 0; c < 4; c++) step(4'b1111, {4'hE, 4'hD, 4'hC, 4'hB}, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Random stress: a pending beat is usually held until accepted
    rv = 4'b0;
    rd = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (rv[i] && !last_ready[i]) begin
          if ($urandom_range(0, 15) == 0) rv[i] = 1'b0;
        end else begin
          rv[i] = ($urandom_range(0, 1) == 1);
          rd[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        end
      end
      step(rv, rd, ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("drain_queue", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/round_robin_mux_4.md
ROUND_ROBIN_MUX_4 -- requirements
Module: round_robin_mux_4

Interface
REQ-001 Parameter: WIDTH, default 4, data width of every channel and of the output.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 in_valid  input  4  bit i set: channel i presents a beat.
REQ-005 in_data0, in_data1, in_data2, in_data3  input  WIDTH each  channel payloads.
REQ-006 in_ready  output  4  bit i set: channel i beat accepted this cycle.
REQ-007 out_valid  output  1  output register holds a beat.
REQ-008 out_data  output  WIDTH  payload of held beat.
REQ-009 out_sel  output  2  index of source channel of held beat, usable as a 4:1 mux select.
REQ-010 out_ready  input  1  downstream accepts held beat this cycle.

Function
REQ-011 Transfer on channel i: in_valid[i] && in_ready[i] at a rising clk edge; output transfer: out_valid && out_ready at a rising edge.
REQ-012 load = !out_valid || out_ready (combinational); no input beat is accepted unless load = 1.
REQ-013 Round-robin pointer ptr (2 bits, reset 0) names the highest-priority channel; priority order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-014 grant = one-hot of the first channel in priority order with in_valid set; grant = 0 when in_valid = 0.
REQ-015 in_ready = grant when load = 1, otherwise 4'b0000; in_ready is at most one-hot.
REQ-016 in_ready shall not depend on in_data*; it depends combinationally on in_valid, out_valid, out_ready, ptr only.
REQ-017 On an input transfer from channel k: out_data <= in_datak, out_sel <= k, out_valid <= 1, ptr <= (k+1) mod 4.
REQ-018 load = 1 with in_valid = 0: out_valid <= 0; out_data, out_sel, ptr hold.
REQ-019 load = 0: out_valid, out_data, out_sel, ptr hold unchanged (stall-stable while out_valid && !out_ready).
REQ-020 Latency: accepted beat appears on out_* the cycle after its input transfer.
REQ-021 Throughput: one beat per cycle sustained while out_ready = 1; simultaneous output transfer and input transfer in one cycle is a replace, no bubble.
REQ-022 Fairness: with all four in_valid held high and out_ready = 1, grants cycle 0,1,2,3,0,...; no channel waits more than 3 transfers after request.
REQ-023 ptr wraps 3 -> 0; granting channel 3 sets ptr to 0.
REQ-024 A channel deasserting in_valid without a transfer is legal; pointer unaffected.
REQ-025 No beat is duplicated or dropped: each input transfer yields exactly one output transfer, in grant order.

Reset
REQ-026 rst_n low asynchronously forces out_valid = 0, out_data = 0, out_sel = 0, ptr = 0 without a clock edge.
REQ-027 While rst_n low, in_ready = 4'b0000 is not required but out_valid stays 0; any beat held at reset assertion is discarded.
REQ-028 First rising edge after rst_n deasserts operates normally with channel 0 highest priority.

Verification
REQ-029 Reset, in_valid = 4'b1111, data0..3 = 1,2,3,4, out_ready = 1 for 5 cycles -> out_sel sequence 0,1,2,3,0, out_data 1,2,3,4,1, one per cycle after first-cycle latency.
REQ-030 Only in_valid[2] = 1, data2 = 4'hA, out_ready = 0 -> in_ready = 4'b0100 first cycle, then out_valid = 1, out_data = 4'hA, out_sel = 2, in_ready = 0 and outputs frozen until out_ready = 1.
REQ-031 ptr = 3 (after granting 2), in_valid = 4'b1001 -> channel 3 granted, next ptr = 0, next grant channel 0.
REQ-032 Stalled output with out_ready rising and in_valid[1] = 1 same cycle -> held beat leaves and channel 1 beat loaded same edge, out_valid stays 1.
REQ-033 rst_n pulsed low mid-stream between clock edges -> out_valid = 0, out_data = 0, out_sel = 0 immediately; after release grant order restarts at channel 0.
REQ-034 Random valid/ready stress, 10000 cycles -> scoreboard: every input beat output exactly once, per-channel order preserved, no channel starved beyond 3 competing transfers.
